// File: rtl/errm_pkg.sv
// Shared state encoding and default widths for the error-metric accumulator.
package errm_pkg;

  localparam int unsigned W_DEF     = 16;
  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned FRAC_DEF  = 16;
  localparam int unsigned ACC_W_DEF = 48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, N cycles from start to done.
module seq_divider #(
  parameter int unsigned N = 32,
  parameter int unsigned D = 16
) (
  input  logic         clk,
  input  logic         i_abort,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [D-1:0] i_divisor,
  output logic         o_done,
  output logic [N-1:0] o_quotient
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]  r_quo;
  logic [D-1:0]  r_rem;
  logic [D-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [D:0]    w_shift;
  logic          w_ge;
  logic [D-1:0]  w_sub;
  logic [D-1:0]  w_rem_nx;

  // Remainder stays below the divisor, so the D-bit wrapped difference is exact
  // whenever the trial subtraction succeeds.
  assign w_shift  = {r_rem, r_quo[N-1]};
  assign w_ge     = (w_shift >= {1'b0, r_div});
  assign w_sub    = w_shift[D-1:0] - r_div;
  assign w_rem_nx = w_ge ? w_sub : w_shift[D-1:0];

  always_ff @(posedge clk) begin
    if (i_abort) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_quo <= {r_quo[N-2:0], w_ge};
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/err_metric_acc.sv
// Streaming accumulator of ER/MED/MRED/max-error raw terms for approximate
// multiplier characterisation; host divides by the sample count.
module err_metric_acc
  import errm_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact,
  input  logic [W-1:0]     apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples_seen,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W:0]   sum_ed,
  output logic [ACC_W-1:0] sum_ed_abs,
  output logic [W-1:0]     max_ed,
  output logic [ACC_W-1:0] sum_re,
  output logic             sat
);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_samples;
  logic [CNT_W-1:0] r_err_count;
  logic [ACC_W:0]   r_sum_ed;
  logic [ACC_W-1:0] r_sum_ed_abs;
  logic [W-1:0]     r_max_ed;
  logic [ACC_W-1:0] r_sum_re;
  logic             r_sat;
  logic             r_done;

  logic             w_accept;
  logic             w_err;
  logic [W:0]       w_ed;
  logic [W-1:0]     w_abs;
  logic             w_need_div;
  logic             w_last;
  logic             w_div_done;
  logic [W+FRAC-1:0] w_quo;

  logic [ACC_W+1:0] w_sum_ed_x;
  logic             w_ovf_ed;
  logic [ACC_W:0]   w_sum_ed_nx;
  logic [ACC_W:0]   w_abs_x;
  logic [ACC_W-1:0] w_sum_abs_nx;
  logic [ACC_W:0]   w_re_x;
  logic [ACC_W-1:0] w_sum_re_nx;

  assign w_accept   = in_valid && (r_state == S_RUN);
  assign w_err      = (exact != apprx);
  assign w_ed       = {1'b0, exact} - {1'b0, apprx};
  assign w_abs      = (exact >= apprx) ? (exact - apprx) : (apprx - exact);
  assign w_need_div = w_accept && w_err && (exact != '0);
  assign w_last     = ((r_samples + CNT_W'(1)) == r_count);

  // Widen by one bit and detect overflow from the top two bits for signed clamping.
  assign w_sum_ed_x  = {r_sum_ed[ACC_W], r_sum_ed} + {{(ACC_W+1-W){w_ed[W]}}, w_ed};
  assign w_ovf_ed    = (w_sum_ed_x[ACC_W+1] != w_sum_ed_x[ACC_W]);
  assign w_sum_ed_nx = !w_ovf_ed ? w_sum_ed_x[ACC_W:0] :
                       w_sum_ed_x[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};

  assign w_abs_x      = {1'b0, r_sum_ed_abs} + {{(ACC_W+1-W){1'b0}}, w_abs};
  assign w_sum_abs_nx = w_abs_x[ACC_W] ? '1 : w_abs_x[ACC_W-1:0];

  assign w_re_x      = {1'b0, r_sum_re} + {{(ACC_W+1-W-FRAC){1'b0}}, w_quo};
  assign w_sum_re_nx = w_re_x[ACC_W] ? '1 : w_re_x[ACC_W-1:0];

  seq_divider #(
    .N(W + FRAC),
    .D(W)
  ) u_div (
    .clk        (clk),
    .i_abort    (rst),
    .i_start    (w_need_div),
    .i_dividend ({w_abs, {FRAC{1'b0}}}),
    .i_divisor  (exact),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_samples    <= '0;
      r_err_count  <= '0;
      r_sum_ed     <= '0;
      r_sum_ed_abs <= '0;
      r_max_ed     <= '0;
      r_sum_re     <= '0;
      r_sat        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_count      <= sample_count;
            r_samples    <= '0;
            r_err_count  <= '0;
            r_sum_ed     <= '0;
            r_sum_ed_abs <= '0;
            r_max_ed     <= '0;
            r_sum_re     <= '0;
            r_sat        <= 1'b0;
            if (sample_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_samples    <= r_samples + CNT_W'(1);
            r_err_count  <= r_err_count + CNT_W'(w_err);
            r_sum_ed     <= w_sum_ed_nx;
            r_sum_ed_abs <= w_sum_abs_nx;
            r_sat        <= r_sat | w_ovf_ed | w_abs_x[ACC_W];
            if (w_abs > r_max_ed) r_max_ed <= w_abs;
            if (w_need_div) begin
              r_state <= S_DIV;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_sum_re <= w_sum_re_nx;
            r_sat    <= r_sat | w_re_x[ACC_W];
            if (r_samples == r_count) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == S_RUN);
  assign busy         = (r_state == S_RUN) || (r_state == S_DIV);
  assign done         = r_done;
  assign samples_seen = r_samples;
  assign err_count    = r_err_count;
  assign sum_ed       = r_sum_ed;
  assign sum_ed_abs   = r_sum_ed_abs;
  assign max_ed       = r_max_ed;
  assign sum_re       = r_sum_re;
  assign sat          = r_sat;

endmodule

// File: tb/tb_err_metric_acc.sv
// Randomised bench for err_metric_acc: two instances (default and narrow
// accumulators) share stimulus and are compared with a per-sample reference model.
module tb_err_metric_acc;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [31:0] sample_count;
  logic [15:0] exact, apprx;

  logic        in_ready_0, busy_0, done_0, sat_0;
  logic [31:0] seen_0, errs_0;
  logic [48:0] sum_ed_0;
  logic [47:0] sum_abs_0, sum_re_0;
  logic [15:0] max_ed_0;

  logic        in_ready_1, busy_1, done_1, sat_1;
  logic [31:0] seen_1, errs_1;
  logic [34:0] sum_ed_1;
  logic [33:0] sum_abs_1, sum_re_1;
  logic [15:0] max_ed_1;

  err_metric_acc u_dut0 (
    .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .in_valid(in_valid), .in_ready(in_ready_0), .exact(exact), .apprx(apprx),
    .busy(busy_0), .done(done_0), .samples_seen(seen_0), .err_count(errs_0),
    .sum_ed(sum_ed_0), .sum_ed_abs(sum_abs_0), .max_ed(max_ed_0),
    .sum_re(sum_re_0), .sat(sat_0)
  );

  err_metric_acc #(.ACC_W(34)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .in_valid(in_valid), .in_ready(in_ready_1), .exact(exact), .apprx(apprx),
    .busy(busy_1), .done(done_1), .samples_seen(seen_1), .err_count(errs_1),
    .sum_ed(sum_ed_1), .sum_ed_abs(sum_abs_1), .max_ed(max_ed_1),
    .sum_re(sum_re_1), .sat(sat_1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt_0 = 0;
  int done_cnt_1 = 0;

  always @(posedge clk) begin
    if (done_0) done_cnt_0++;
    if (done_1) done_cnt_1++;
  end

  int unsigned q_ex[$];
  int unsigned q_ap[$];

  typedef struct {
    longint errs;
    longint sum_ed;
    longint sum_abs;
    longint max_ed;
    longint sum_re;
    longint sat;
  } res_t;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies each sample's rules in order, clamping after every addition.
  function automatic res_t model(input int acc_w);
    res_t   r;
    longint lim;
    longint d, a;
    r   = '{default: 0};
    lim = (longint'(1) << acc_w) - 1;
    foreach (q_ex[i]) begin
      d = longint'(q_ex[i]) - longint'(q_ap[i]);
      a = (d < 0) ? -d : d;
      if (d != 0) r.errs++;
      r.sum_ed += d;
      if (r.sum_ed > lim) begin r.sum_ed = lim; r.sat = 1; end
      if (r.sum_ed < -lim - 1) begin r.sum_ed = -lim - 1; r.sat = 1; end
      r.sum_abs += a;
      if (r.sum_abs > lim) begin r.sum_abs = lim; r.sat = 1; end
      if (a > r.max_ed) r.max_ed = a;
      if (q_ex[i] != 0 && d != 0) begin
        r.sum_re += (a << 16) / longint'(q_ex[i]);
        if (r.sum_re > lim) begin r.sum_re = lim; r.sat = 1; end
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned cnt);
    q_ex.delete();
    q_ap.delete();
    start        = 1'b1;
    sample_count = cnt;
    tick();
    start        = 1'b0;
    sample_count = $urandom;
  endtask

  task automatic send(input int unsigned e, input int unsigned a, output int low);
    logic acc_now;
    bit   accepted;
    in_valid = 1'b1;
    exact    = e[15:0];
    apprx    = a[15:0];
    low      = 0;
    accepted = 0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      acc_now = in_ready_0;
      tick();
      if (acc_now) accepted = 1;
      else low++;
    end
    if (!accepted) check_val("accept_timeout", 0, 1);
    q_ex.push_back(e);
    q_ap.push_back(a);
  endtask

  task automatic check_results(input string tag);
    res_t m0, m1;
    m0 = model(48);
    m1 = model(34);
    check_val({tag, "/seen0"},   seen_0,              q_ex.size());
    check_val({tag, "/errs0"},   errs_0,              m0.errs);
    check_val({tag, "/ed0"},     $signed(sum_ed_0),   m0.sum_ed);
    check_val({tag, "/abs0"},    sum_abs_0,           m0.sum_abs);
    check_val({tag, "/max0"},    max_ed_0,            m0.max_ed);
    check_val({tag, "/re0"},     sum_re_0,            m0.sum_re);
    check_val({tag, "/sat0"},    sat_0,               m0.sat);
    check_val({tag, "/seen1"},   seen_1,              q_ex.size());
    check_val({tag, "/errs1"},   errs_1,              m1.errs);
    check_val({tag, "/ed1"},     $signed(sum_ed_1),   m1.sum_ed);
    check_val({tag, "/abs1"},    sum_abs_1,           m1.sum_abs);
    check_val({tag, "/max1"},    max_ed_1,            m1.max_ed);
    check_val({tag, "/re1"},     sum_re_1,            m1.sum_re);
    check_val({tag, "/sat1"},    sat_1,               m1.sat);
  endtask

  task automatic finish_campaign(input string tag);
    int d0, d1;
    d0 = done_cnt_0;
    d1 = done_cnt_1;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !done_0; i++) tick();
    check_val({tag, "/done"}, done_0, 1);
    check_val({tag, "/busy"}, busy_0, 0);
    check_val({tag, "/rdy"},  in_ready_0, 0);
    check_results(tag);
    tick();
    tick();
    check_val({tag, "/npulse0"}, done_cnt_0 - d0, 1);
    check_val({tag, "/npulse1"}, done_cnt_1 - d1, 1);
    check_results({tag, "/hold"});
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "/rdy"},  in_ready_0, 0);
    check_val({tag, "/busy"}, busy_0, 0);
    check_val({tag, "/done"}, done_0, 0);
    check_val({tag, "/seen"}, seen_0, 0);
    check_val({tag, "/errs"}, errs_0, 0);
    check_val({tag, "/ed"},   sum_ed_0, 0);
    check_val({tag, "/abs"},  sum_abs_0, 0);
    check_val({tag, "/max"},  max_ed_0, 0);
    check_val({tag, "/re"},   sum_re_0, 0);
    check_val({tag, "/sat"},  sat_0, 0);
    check_val({tag, "/re1"},  sum_re_1, 0);
    check_val({tag, "/rdy1"}, in_ready_1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int low, low2, d0;
    int unsigned n, e, a, mode;

    // Reset with random inputs applied
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start        = 1'($urandom);
      in_valid     = 1'($urandom);
      sample_count = $urandom;
      exact        = 16'($urandom);
      apprx        = 16'($urandom);
      tick();
    end
    check_cleared("reset");
    check_val("reset/nodone", done_cnt_0 + done_cnt_1, 0);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Basic campaign
    do_start(3);
    check_val("basic/rdy_after_start", in_ready_0, 1);
    send(100, 100, low);
    check_val("basic/seen_after_1", seen_0, 1);
    send(200, 190, low);
    send(0, 5, low);
    finish_campaign("basic");
    check_val("basic/re_const",  sum_re_0, 3276);
    check_val("basic/ed_const",  $signed(sum_ed_0), 5);
    check_val("basic/abs_const", sum_abs_0, 15);
    check_val("basic/max_const", max_ed_0, 10);
    check_val("basic/err_const", errs_0, 2);

    // Backpressure: valid held across the divide
    do_start(2);
    send(50, 40, low);
    check_val("bp/first_wait", low, 0);
    send(50, 50, low2);
    check_val("bp/ready_low_cycles", low2, 33);
    finish_campaign("bp");

    // Saturation of the narrow sum_re
    do_start(6);
    for (int i = 0; i < 6; i++) begin
      send(1, 65535, low);
      if (i == 3) begin
        // fourth RE is still being divided; check after it lands
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !in_ready_0; k++) tick();
        check_val("sat/pre5_sat1", sat_1, 0);
      end
    end
    finish_campaign("sat");
    check_val("sat/re1_clamp", sum_re_1, (longint'(1) << 34) - 1);
    check_val("sat/sat1",      sat_1, 1);
    check_val("sat/sat0",      sat_0, 0);
    check_val("sat/max",       max_ed_1, 65534);
    check_val("sat/errs",      errs_1, 6);

    // Zero count
    d0 = done_cnt_0;
    do_start(0);
    check_val("zero/done", done_0, 1);
    check_val("zero/rdy",  in_ready_0, 0);
    check_val("zero/busy", busy_0, 0);
    check_results("zero");
    tick();
    check_val("zero/rdy_later",  in_ready_0, 0);
    check_val("zero/one_pulse",  done_cnt_0 - d0, 1);

    // start while RUN is ignored
    do_start(3);
    send(5, 5, low);
    in_valid     = 1'b0;
    start        = 1'b1;
    sample_count = 1;
    tick();
    start = 1'b0;
    check_val("ign/busy", busy_0, 1);
    send(7, 3, low);
    send(9, 9, low);
    finish_campaign("ign");

    // rst in the middle of a divide
    do_start(2);
    send(300, 1, low);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_val("abort/in_div", busy_0, 1);
    d0  = done_cnt_0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("abort");
    for (int i = 0; i < 40; i++) tick();
    check_val("abort/nodone", done_cnt_0 - d0, 0);
    check_val("abort/idle",   busy_0, 0);

    // Random campaigns
    for (int c = 0; c < 10; c++) begin
      n = $urandom_range(1, 8);
      do_start(n);
      for (int s = 0; s < int'(n); s++) begin
        if ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          exact    = 16'($urandom);
          apprx    = 16'($urandom);
          for (int g = 0; g < int'($urandom_range(1, 2)); g++) tick();
        end
        mode = $urandom_range(0, 3);
        e = $urandom_range(0, 65535);
        a = $urandom_range(0, 65535);
        case (mode)
          0: a = e;
          1: e = 0;
          3: a = (e > 20) ? e - $urandom_range(0, 20) : e + $urandom_range(0, 20);
          default: ;
        endcase
        send(e, a, low);
      end
      finish_campaign($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
